// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and the
// clocks-per-bit helper used by both the receiver and the transmitter.
package uart_pkg;

  // Payload bits per 8N1 frame
  localparam int DATA_BITS = 8;

  // Bits on the wire per frame: start + data + stop
  localparam int FRAME_BITS = DATA_BITS + 2;

  // Smallest usable oversampling ratio; below this the mid-bit point and
  // the half-bit start qualification collapse into each other.
  localparam int MIN_CLKS_PER_BIT = 4;

  // Receiver / transmitter state encoding
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  // Integer clocks per bit period for a given system clock and line rate
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. The reset value is a
// parameter so idle-high lines (UART rx) come out of reset in their idle state
// and cannot fake an edge.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // Metastability capture stage followed by the settled output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first. Qualifies the start bit at its midpoint to
// reject glitches, samples each data bit at mid-bit, checks the stop bit and
// hands bytes to a consumer over a valid/ready handshake with overrun and
// framing-error pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_ratio
      $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic                 rx_s;
  logic                 rx_s_d;
  logic                 fall;
  uart_state_t          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_tick;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Previous synchronized level for start-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s_d <= 1'b1;
    end else begin
      rx_s_d <= rx_s;
    end
  end

  assign fall     = rx_s_d & ~rx_s;
  assign bit_tick = (clk_cnt == BIT_LAST);

  // Data shift register: payload only, so it needs no reset; a partial byte
  // left behind by an aborted frame is overwritten before it can be loaded.
  always_ff @(posedge clk) begin
    if (state == DATA && bit_tick) begin
      shift <= {rx_s, shift[DATA_BITS-1:1]};
    end
  end

  // Receive FSM with registered outputs and the consumer handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a byte completing on this same edge overrides it below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high before mid start bit: glitch
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ready;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              // Bad stop bit: drop the byte and wait out the low line
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: drives 8N1 frames on rx, keeps a queue of the bytes
// that should come out and compares each byte as it is presented.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor statistics
  int fe_cnt     = 0;
  int ov_cnt     = 0;
  int vld_cycles = 0;
  int n_pres     = 0;

  logic [7:0] exp_q[$];
  bit prev_vld  = 1'b0;
  bit prev_take = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the stop bit ends.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: a byte is "presented" when rx_valid rises, or when new data
  // replaces the current byte (overrun, or consume and complete together).
  always @(negedge clk) begin
    if (reset) begin
      prev_vld  = 1'b0;
      prev_take = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) vld_cycles++;
      if (rx_valid && (!prev_vld || prev_take || overrun)) begin
        n_pres++;
        if (exp_q.size() == 0) check("sb_pending", exp_q.size(), 1);
        else check("sb_data", rx_data, exp_q.pop_front());
      end
      prev_vld  = rx_valid;
      prev_take = rx_valid && rx_ready;
    end
  end

  initial begin
    int fe0, ov0, vc0, np0, lat, busy_n;

    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(10);

    // Single byte, consumer always ready; also measure latency
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vld_cycles;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 300 && !rx_valid) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    idle(10);
    check("a5_latency_ok", (lat >= 153 && lat <= 155), 1);
    check("a5_vld_cycles", vld_cycles - vc0, 1);
    check("a5_ferr", fe_cnt - fe0, 0);
    check("a5_ovr", ov_cnt - ov0, 0);

    // Back-to-back bytes with no consumer: second overwrites first
    rx_ready = 1'b0;
    ov0 = ov_cnt; np0 = n_pres;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_pres", n_pres - np0, 2);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'hC3);
    rx_ready = 1'b1;
    idle(1);
    check("ovr_consumed", rx_valid, 0);
    idle(10);

    // Short glitch on the line: must be rejected silently
    fe0 = fe_cnt; np0 = n_pres;
    busy_n = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) rx = 1'b1;
      if (busy) busy_n++;
    end
    check("glitch_busy_ok", (busy_n > 0 && busy_n <= 10), 1);
    check("glitch_idle", busy, 0);
    check("glitch_pres", n_pres - np0, 0);
    check("glitch_ferr", fe_cnt - fe0, 0);

    // Framing error followed by a break, then a clean byte
    fe0 = fe_cnt; np0 = n_pres;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    idle(40);
    check("brk_valid", rx_valid, 0);
    check("brk_busy", busy, 1);
    rx = 1'b1;
    idle(20);
    check("brk_ferr", fe_cnt - fe0, 1);
    check("brk_pres", n_pres - np0, 0);
    rx_ready = 1'b0;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(4);
    check("f0_valid", rx_valid, 1);
    check("f0_data", rx_data, 8'h0F);
    rx_ready = 1'b1;
    idle(10);

    // Reset pulse in the middle of bit 4 of an 8'hFF frame
    fe0 = fe_cnt; ov0 = ov_cnt; np0 = n_pres;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(86);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
      end
    join
    idle(40);
    check("abort_pres", n_pres - np0, 0);
    check("abort_ferr", fe_cnt - fe0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(10);
    check("r81_pres", n_pres - np0, 1);

    // Counter-style stream 0..15, back to back
    fe0 = fe_cnt; ov0 = ov_cnt; np0 = n_pres;
    for (int v = 0; v < 16; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    idle(20);
    check("loop_pres", n_pres - np0, 16);
    check("loop_ferr", fe_cnt - fe0, 0);
    check("loop_ovr", ov_cnt - ov0, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
